// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared icode, status, register and FSM state constants for
// the pipeline control block, plus a helper classifying terminating status.
package pipe_ctrl_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // "No register" destination id
  localparam logic [3:0] RNONE = 4'hF;

  // Pipeline status codes
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // A status that terminates the program once it reaches writeback
  function automatic logic is_exc(input logic [2:0] stat);
    return (stat == SADR) || (stat == SINS) || (stat == SHLT);
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with enable; sticks at all-ones.
module pipe_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  // Count enabled cycles, holding once every bit is set
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_cnt <= '0;
    else if (en_i && !(&r_cnt))
      r_cnt <= r_cnt + 1'b1;
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard detection and stall/bubble control for a five-stage
// pipeline, with an INIT/RUN/DRAIN/HALT FSM that freezes the pipe after a
// terminating status reaches writeback.
// Optional build macro PIPE_CTRL_PERF_EN adds load-use, mispredict and
// ret-bubble event counters; without it the counter outputs read zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  D_icode_i,
  input  logic [3:0]  d_srcA_i,
  input  logic [3:0]  d_srcB_i,
  input  logic [3:0]  E_icode_i,
  input  logic [3:0]  E_dstM_i,
  input  logic        e_Cnd_i,
  input  logic [3:0]  M_icode_i,
  input  logic [2:0]  m_stat_i,
  input  logic [2:0]  W_stat_i,
  output logic        F_stall_o,
  output logic        D_stall_o,
  output logic        D_bubble_o,
  output logic        E_bubble_o,
  output logic        M_bubble_o,
  output logic        W_stall_o,
  output logic        set_cc_en_o,
  output logic [1:0]  state_o,
  output logic        halted_o,
  output logic [2:0]  final_stat_o,
  output logic [31:0] lu_cnt_o,
  output logic [31:0] mp_cnt_o,
  output logic [31:0] ret_cnt_o
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_final_stat;

  logic w_load_use;
  logic w_ret_in;
  logic w_mispred;
  logic w_exc_m;
  logic w_exc_w;
  logic w_ret_bub;

  assign w_load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                      (E_dstM_i != RNONE) &&
                      ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign w_ret_in   = (D_icode_i == IRET) || (E_icode_i == IRET) ||
                      (M_icode_i == IRET);
  assign w_mispred  = (E_icode_i == IJXX) && !e_Cnd_i;
  assign w_exc_m    = is_exc(m_stat_i);
  assign w_exc_w    = is_exc(W_stat_i);
  // A load-use stall holds the ret in D, so the bubble is suppressed then
  assign w_ret_bub  = w_ret_in && !w_load_use;

  // State register; terminating status captured on the way into HALT
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_INIT;
      r_final_stat <= SAOK;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt == ST_HALT) && (r_state != ST_HALT))
        r_final_stat <= W_stat_i;
    end
  end

  // Next-state and stage-control decode
  always_comb begin
    w_state_nxt = r_state;
    F_stall_o   = 1'b0;
    D_stall_o   = 1'b0;
    D_bubble_o  = 1'b0;
    E_bubble_o  = 1'b0;
    M_bubble_o  = 1'b0;
    W_stall_o   = 1'b0;
    set_cc_en_o = 1'b0;
    case (r_state)
      ST_INIT: begin
        F_stall_o   = 1'b1;
        D_bubble_o  = 1'b1;
        E_bubble_o  = 1'b1;
        M_bubble_o  = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        F_stall_o   = w_load_use || w_ret_in;
        D_stall_o   = w_load_use;
        D_bubble_o  = w_mispred || w_ret_bub;
        E_bubble_o  = w_mispred || w_load_use;
        M_bubble_o  = w_exc_m || w_exc_w;
        W_stall_o   = w_exc_w;
        set_cc_en_o = !w_exc_m && !w_exc_w;
        if (w_exc_w)
          w_state_nxt = ST_HALT;
        else if ((r_state == ST_RUN) && w_exc_m)
          w_state_nxt = ST_DRAIN;
      end
      default: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
      end
    endcase
  end

  assign state_o      = r_state;
  assign halted_o     = (r_state == ST_HALT);
  assign final_stat_o = r_final_stat;

`ifdef PIPE_CTRL_PERF_EN
  logic w_run;
  assign w_run = (r_state == ST_RUN);

  pipe_sat_cnt #(.WIDTH(32)) u_lu_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_run && w_load_use),
    .cnt_o   (lu_cnt_o)
  );

  pipe_sat_cnt #(.WIDTH(32)) u_mp_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_run && w_mispred),
    .cnt_o   (mp_cnt_o)
  );

  pipe_sat_cnt #(.WIDTH(32)) u_ret_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_run && w_ret_bub),
    .cnt_o   (ret_cnt_o)
  );
`else
  assign lu_cnt_o  = 32'd0;
  assign mp_cnt_o  = 32'd0;
  assign ret_cnt_o = 32'd0;
`endif

endmodule
